// File: rtl/latch_bank_pkg.sv
// Shared types and helpers for the latch bank write sequencer.
package latch_bank_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_GATE,
    S_HOLD,
    S_ACK
  } state_t;

  localparam int CNT_W = 4;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/latch_bank_sequencer_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// the search start index, wrapping modulo NREQ.
module rr_arbiter
  import latch_bank_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]        req,
  input  logic [clog2(NREQ)-1:0] pointer,
  output logic [NREQ-1:0]        grant,
  output logic [clog2(NREQ)-1:0] grant_idx
);

  localparam int IW = clog2(NREQ);

  // Scan from farthest to nearest so the nearest active requester wins.
  always_comb begin
    int j;
    logic [IW-1:0] idx;
    grant     = '0;
    grant_idx = '0;
    j         = 0;
    idx       = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(pointer) + k;
      if (j >= NREQ) begin
        j = j - NREQ;
      end
      idx = IW'(j);
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/latch_bank_sequencer.sv
// Round-robin setup/gate/hold write sequencer for a shared bank of D-latch words.
// Optional readback check enabled by defining LATCH_BANK_READBACK_EN.
module latch_bank_sequencer
  import latch_bank_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int NLAT      = 8,
  parameter int DW        = 8,
  parameter int SETUP_CYC = 1,
  parameter int GATE_CYC  = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic                          Clk,
  input  logic                          Resetn,
  input  logic [NREQ-1:0]               req,
  input  logic [NREQ*clog2(NLAT)-1:0]   wr_addr,
  input  logic [NREQ*DW-1:0]            wr_data,
`ifdef LATCH_BANK_READBACK_EN
  input  logic [NLAT*DW-1:0]            lat_q,
  output logic                          wr_err,
  output logic [clog2(NREQ)-1:0]        err_id,
`endif
  output logic [NREQ-1:0]               ack,
  output logic [DW-1:0]                 lat_d,
  output logic [NLAT-1:0]               lat_gate,
  output logic                          busy,
  output logic [clog2(NREQ)-1:0]        grant_id
);

  localparam int AW = clog2(NLAT);
  localparam int IW = clog2(NREQ);
  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] GATE_LOAD  = CNT_W'(GATE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYC - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [AW-1:0]    addr_reg;
  logic [DW-1:0]    data_reg;
  logic [IW-1:0]    grant_reg;
  logic [NREQ-1:0]  grant_oh_reg;
  logic [IW-1:0]    ptr_reg;
  logic [NREQ-1:0]  arb_grant;
  logic [IW-1:0]    arb_idx;
  logic [AW-1:0]    addr_arr [NREQ];
  logic [DW-1:0]    data_arr [NREQ];
  logic [NLAT-1:0]  gate_dec;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign addr_arr[gi] = wr_addr[gi*AW +: AW];
      assign data_arr[gi] = wr_data[gi*DW +: DW];
    end
    for (gi = 0; gi < NLAT; gi++) begin : g_gate_dec
      assign gate_dec[gi] = (addr_reg == AW'(gi));
    end
  endgenerate

  // ptr_reg holds the next search start (last grant + 1), so reset value 0
  // gives requester 0 top priority on the first grant.
  rr_arbiter #(
    .NREQ(NREQ)
  ) u_arb (
    .req      (req),
    .pointer  (ptr_reg),
    .grant    (arb_grant),
    .grant_idx(arb_idx)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (|req) begin
          state_next = S_SETUP;
          cnt_next   = SETUP_LOAD;
        end
      end
      S_SETUP: begin
        if (cnt_reg == '0) begin
          state_next = S_GATE;
          cnt_next   = GATE_LOAD;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      S_GATE: begin
        if (cnt_reg == '0) begin
          state_next = S_HOLD;
          cnt_next   = HOLD_LOAD;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt_reg == '0) begin
          state_next = S_ACK;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      S_ACK: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Gate, ack and busy are registered from state_next so the latch enables
  // come straight off flops and stay glitch-free.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= '0;
      addr_reg     <= '0;
      data_reg     <= '0;
      grant_reg    <= '0;
      grant_oh_reg <= '0;
      ptr_reg      <= '0;
      lat_gate     <= '0;
      ack          <= '0;
      busy         <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (state_reg == S_IDLE && |req) begin
        addr_reg     <= addr_arr[arb_idx];
        data_reg     <= data_arr[arb_idx];
        grant_reg    <= arb_idx;
        grant_oh_reg <= arb_grant;
      end
      if (state_reg == S_ACK) begin
        ptr_reg <= (grant_reg == IW'(NREQ - 1)) ? '0 : grant_reg + IW'(1);
      end
      lat_gate <= (state_next == S_GATE) ? gate_dec : '0;
      ack      <= (state_next == S_ACK) ? grant_oh_reg : '0;
      busy     <= (state_next == S_SETUP) || (state_next == S_GATE) ||
                  (state_next == S_HOLD);
    end
  end

  assign lat_d    = data_reg;
  assign grant_id = grant_reg;

`ifdef LATCH_BANK_READBACK_EN
  logic [DW-1:0] q_arr [NLAT];

  generate
    for (gi = 0; gi < NLAT; gi++) begin : g_q_unpack
      assign q_arr[gi] = lat_q[gi*DW +: DW];
    end
  endgenerate

  // Sticky: only the first failing write is recorded.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      wr_err <= 1'b0;
      err_id <= '0;
    end else if (state_reg == S_ACK && !wr_err && q_arr[addr_reg] != data_reg) begin
      wr_err <= 1'b1;
      err_id <= grant_reg;
    end
  end
`endif

endmodule

// File: tb/tb_latch_bank_sequencer.sv
// Directed self-checking bench for latch_bank_sequencer (default and slow timing).
module tb_latch_bank_sequencer;

  logic        Clk;
  logic        Resetn;
  logic [3:0]  req, req_s;
  logic [11:0] wr_addr, wr_addr_s;
  logic [31:0] wr_data, wr_data_s;
  logic [3:0]  ack, ack_s;
  logic [7:0]  lat_d, lat_d_s;
  logic [7:0]  lat_gate, lat_gate_s;
  logic        busy, busy_s;
  logic [1:0]  grant_id, grant_id_s;
  logic [7:0]  bank [8];
  logic        force5;
  int          n_cmp = 0;
  int          n_err = 0;

`ifdef LATCH_BANK_READBACK_EN
  logic [63:0] lat_q;
  logic [63:0] lat_q_s;
  logic        wr_err, wr_err_s;
  logic [1:0]  err_id, err_id_s;
  assign lat_q_s = '0;

  always_comb begin
    lat_q = '0;
    for (int i = 0; i < 8; i++) begin
      lat_q[i*8 +: 8] = (force5 && i == 5) ? 8'h00 : bank[i];
    end
  end
`endif

  latch_bank_sequencer u_dut (
    .Clk     (Clk),
    .Resetn  (Resetn),
    .req     (req),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
`ifdef LATCH_BANK_READBACK_EN
    .lat_q   (lat_q),
    .wr_err  (wr_err),
    .err_id  (err_id),
`endif
    .ack     (ack),
    .lat_d   (lat_d),
    .lat_gate(lat_gate),
    .busy    (busy),
    .grant_id(grant_id)
  );

  latch_bank_sequencer #(
    .SETUP_CYC(3),
    .GATE_CYC (1),
    .HOLD_CYC (2)
  ) u_slow (
    .Clk     (Clk),
    .Resetn  (Resetn),
    .req     (req_s),
    .wr_addr (wr_addr_s),
    .wr_data (wr_data_s),
`ifdef LATCH_BANK_READBACK_EN
    .lat_q   (lat_q_s),
    .wr_err  (wr_err_s),
    .err_id  (err_id_s),
`endif
    .ack     (ack_s),
    .lat_d   (lat_d_s),
    .lat_gate(lat_gate_s),
    .busy    (busy_s),
    .grant_id(grant_id_s)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Behavioural latch bank fed by the main instance.
  always @(negedge Clk) begin
    for (int i = 0; i < 8; i++) begin
      if (lat_gate[i]) bank[i] <= lat_d;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // One default-timing write from the IDLE window; window w is 1 time unit after
  // edge w. Expect SETUP w1, GATE w2-3, HOLD w4, ACK w5, IDLE w6.
  task automatic txn(input string tag, input logic [3:0] mask, input int g,
                     input int addr, input logic [7:0] data);
    req = mask;
    for (int w = 1; w <= 6; w++) begin
      tick();
      check({tag, "_gate"}, lat_gate, (w == 2 || w == 3) ? (64'd1 << addr) : 64'd0);
      check({tag, "_ack"},  ack,      (w == 5) ? (64'd1 << g) : 64'd0);
      check({tag, "_latd"}, lat_d,    data);
      check({tag, "_busy"}, busy,     (w >= 1 && w <= 4) ? 64'd1 : 64'd0);
      if (w == 1) check({tag, "_gid"}, grant_id, g);
      $display("%s w%0d gate=%02h ack=%h lat_d=%02h busy=%0b", tag, w, lat_gate, ack, lat_d, busy);
      if (w == 5) req = '0;
    end
  endtask

  initial begin
    int off;
    int t;
    int addr_tab [4];
    logic [7:0] data_tab [4];
    addr_tab = '{5, 2, 6, 1};
    data_tab = '{8'h11, 8'h22, 8'h33, 8'h44};

    Resetn = 1'b0;
    req = '0; req_s = '0;
    wr_addr = '0; wr_data = '0; wr_addr_s = '0; wr_data_s = '0;
    force5 = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    check("rst_gate", lat_gate, 0);
    check("rst_latd", lat_d, 0);
    check("rst_ack", ack, 0);
    check("rst_busy", busy, 0);
    check("rst_gid", grant_id, 0);
`ifdef LATCH_BANK_READBACK_EN
    check("rst_err", wr_err, 0);
`endif
    Resetn = 1'b1;
    tick();

    // Test 1: single write, requester 0 to word 3.
    wr_addr[2:0] = 3'd3;
    wr_data[7:0] = 8'hA5;
    txn("t1", 4'b0001, 0, 3, 8'hA5);
    check("t1_bank", bank[3], 8'hA5);

    // Test 2: all requesters held, from a fresh reset.
    Resetn = 1'b0;
    tick();
    Resetn = 1'b1;
    tick();
    wr_addr = {3'd0, 3'd1, 3'd6, 3'd2, 3'd5};
    wr_data = {8'h44, 8'h33, 8'h22, 8'h11};
    req = 4'hF;
    for (int w = 1; w <= 23; w++) begin
      tick();
      off = w % 6;
      t   = w / 6;
      check("t2_gate", lat_gate, (off == 2 || off == 3) ? (64'd1 << addr_tab[t]) : 64'd0);
      check("t2_ack", ack, (off == 5) ? (64'd1 << t) : 64'd0);
      if (off == 1) begin
        check("t2_gid", grant_id, t);
        check("t2_latd", lat_d, data_tab[t]);
      end
      $display("t2 w%0d gate=%02h ack=%h gid=%0d", w, lat_gate, ack, grant_id);
      if (w == 23) req = '0;
    end
    tick();
    check("t2_idle_ack", ack, 0);
    check("t2_idle_busy", busy, 0);

    // Test 3: slow instance, requester 2 to word 6.
    wr_addr_s[8:6]   = 3'd6;
    wr_data_s[23:16] = 8'h3C;
    req_s = 4'b0100;
    for (int w = 1; w <= 8; w++) begin
      tick();
      check("t3_gate", lat_gate_s, (w == 4) ? 64'h40 : 64'd0);
      check("t3_ack", ack_s, (w == 7) ? 64'h4 : 64'd0);
      check("t3_busy", busy_s, (w >= 1 && w <= 6) ? 64'd1 : 64'd0);
      check("t3_latd", lat_d_s, 8'h3C);
      $display("t3 w%0d gate=%02h ack=%h busy=%0b", w, lat_gate_s, ack_s, busy_s);
      if (w == 7) req_s = '0;
    end
`ifdef LATCH_BANK_READBACK_EN
    check("t3_err", wr_err_s, 1);
    check("t3_err_id", err_id_s, 2);
`endif

    // Test 4: reset during GATE; pointer would otherwise favour requester 2.
    txn("t4a", 4'b0010, 1, 2, 8'h22);
    req = 4'b0100;
    tick();
    check("t4_gid", grant_id, 2);
    tick();
    check("t4_gate_on", lat_gate, 64'h40);
    #2 Resetn = 1'b0;
    req = '0;
    #1;
    check("t4_gate_async", lat_gate, 0);
    check("t4_busy", busy, 0);
    check("t4_ack", ack, 0);
    check("t4_gid_rst", grant_id, 0);
    $display("t4 reset gate=%02h ack=%h busy=%0b", lat_gate, ack, busy);
    #2 Resetn = 1'b1;
    tick();
    check("t4_ack_after", ack, 0);
    txn("t4b", 4'b0111, 0, 5, 8'h11);

    // Test 5: data change and req drop during GATE.
    wr_data[23:16] = 8'h11;
    req = 4'b0100;
    tick();
    check("t5_gid", grant_id, 2);
    check("t5_latd1", lat_d, 8'h11);
    tick();
    check("t5_gate", lat_gate, 64'h40);
    wr_data[23:16] = 8'h22;
    req = '0;
    tick();
    check("t5_gate2", lat_gate, 64'h40);
    check("t5_latd3", lat_d, 8'h11);
    tick();
    check("t5_latd4", lat_d, 8'h11);
    check("t5_gate_off", lat_gate, 0);
    tick();
    check("t5_ack", ack, 64'h4);
    check("t5_latd5", lat_d, 8'h11);
    $display("t5 ack=%h lat_d=%02h", ack, lat_d);
    tick();
    check("t5_ack_clr", ack, 0);
    check("t5_bank", bank[6], 8'h11);

`ifdef LATCH_BANK_READBACK_EN
    // Test 6: readback mismatch on word 5, then a passing write.
    check("t6_err_pre", wr_err, 0);
    force5 = 1'b1;
    wr_addr[5:3]  = 3'd5;
    wr_data[15:8] = 8'hFF;
    txn("t6a", 4'b0010, 1, 5, 8'hFF);
    check("t6_err", wr_err, 1);
    check("t6_err_id", err_id, 1);
    wr_addr[2:0] = 3'd2;
    wr_data[7:0] = 8'h77;
    txn("t6b", 4'b0001, 0, 2, 8'h77);
    check("t6_err_hold", wr_err, 1);
    check("t6_err_id_hold", err_id, 1);
    Resetn = 1'b0;
    #1;
    check("t6_err_rst", wr_err, 0);
    check("t6_err_id_rst", err_id, 0);
    Resetn = 1'b1;
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
